row_store_responder: RTL and testbench
======================================

Name: row_store_responder

Overview:
- Responder end of the row-buffer memory handshake (read/write/refresh with per-word acknowledge, 24-bit word address, 16-bit data).
- Backs the requests with an on-chip block-RAM word store clocked on clkDiv.
- Drop-in alternative to the external DDR controller for bring-up and single-clock simulation of the Game of Life row traffic (480 rows × 40 words, row-major address {9'b0, row[8:0], word[5:0]}).

Parameters:
- ADDR_WIDTH, 24, request address width.
- DATA_WIDTH, 16, word width.
- MEM_ADDR_BITS, 15, implemented address bits (32768 words; row[8:0], word[5:0]).
- REFRESH_CYCLES, 8, busy cycles spent per refresh before acknowledge (minimum 1).

Ports:
- clkDiv  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- read  in  1  read request level; held by the requester for a burst.
- readAddress  in  24  word address of the current read.
- readAcknowledge  out  1  one-cycle pulse; readData is valid for readAddress.
- readData  out  16  read word; holds its value until the next read acknowledge.
- write  in  1  write request level.
- writeAddress  in  24  word address of the current write.
- writeData  in  16  word to write.
- writeAcknowledge  out  1  one-cycle pulse; word consumed, requester advances.
- refresh  in  1  refresh request level; requester clears it on acknowledge.
- refreshAcknowledge  out  1  one-cycle pulse; refresh done.
- busy  out  1  high whenever the state is not IDLE.
- rangeError  out  1  sticky; set on any access with address bits [23:15] nonzero.

Behaviour:
- Reset: all outputs 0, readData 0, state IDLE, refresh counter 0. Memory contents are not cleared. Reset mid-operation abandons the access with no acknowledge.
- States: IDLE, WR_ACK, RD_WAIT, RD_ACK, REFRESH, REF_ACK. Requests are sampled only in IDLE.
- Priority at an IDLE edge: refresh > write > read. Refresh asserted during a burst is serviced between words.
- Write path:
  - IDLE edge with write=1: mem[writeAddress[14:0]] <= writeData at that edge; writeAcknowledge <= 1; go to WR_ACK.
  - WR_ACK edge: writeAcknowledge <= 0; go to IDLE.
  - Result: one word per 2 cycles.
- Read path:
  - IDLE edge with read=1: present readAddress[14:0] to the RAM; go to RD_WAIT.
  - RD_WAIT edge: readData <= RAM output; readAcknowledge <= 1; go to RD_ACK.
  - RD_ACK edge: readAcknowledge <= 0; go to IDLE.
  - Result: one word per 3 cycles. The address is captured at the IDLE edge; later address changes do not affect the access.
- Refresh path:
  - IDLE edge with refresh=1: load counter with REFRESH_CYCLES-1; go to REFRESH.
  - REFRESH: decrement each edge. At 0, refreshAcknowledge <= 1 and go to REF_ACK.
  - REF_ACK edge: ack <= 0; go to IDLE.
- Requester contract: the requester updates address/data at the edge where it sees the acknowledge. The ack-to-IDLE cycle guarantees the next sample sees updated values. A request dropped on that same edge produces no further access.
- Request withdrawn mid-access (read low in RD_WAIT, refresh low in REFRESH): the access completes and the acknowledge still pulses.
- Out of range (addr[23:15] != 0):
  - Write: acknowledged normally, memory unchanged.
  - Read: acknowledged with readData = 0.
  - Both set rangeError, which clears only on rst.
- Simultaneous write and read in IDLE: the write is served. The read is served at a later IDLE edge once write is low.
- readAcknowledge, writeAcknowledge and refreshAcknowledge are mutually exclusive, never high in consecutive cycles for the same request type, and each is a single-cycle pulse.

Test Plan:
- Reset, then write=1, writeAddress=24'h000143 (row 5, word 3), writeData=16'hBEEF, dropped on ack; then read=1 at the same address → writeAcknowledge exactly 1 cycle after the sampling edge; readAcknowledge 2 edges after the read sample with readData=16'hBEEF.
- 40-word write burst at row 479 (address 24'h0077C0 onward, data = word index), requester increments on ack and drops write after word 39 → 40 write acks spaced 2 cycles apart, 80 cycles total. Read-back burst → 40 acks spaced 3 cycles apart, readData values 0..39 in order.
- refresh raised during a write burst after word 17 → next IDLE services refresh first; refreshAcknowledge appears REFRESH_CYCLES+1 cycles after the sample; the burst resumes at word 18 with no word skipped or duplicated.
- read and write both high in IDLE → write acked first, no readAcknowledge until write is low; the read then returns the newly written value.
- Write 16'h1234 to 24'h010000 → writeAcknowledge pulses, rangeError=1, mem[0] unchanged. Read of 24'h800005 → readData=0, rangeError stays 1.
- rst asserted in RD_WAIT → all acks 0, busy=0, rangeError=0, readData=0 immediately. After release, previously written data is still readable.

Source files
------------

// File: rtl/row_store_responder.sv
// Responder side of the row-buffer read/write/refresh handshake, backed by an
// on-chip word store so row traffic can run without the external DDR controller.
module row_store_responder #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_ADDR_BITS  = 15,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                  clkDiv,
  input  logic                  rst,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic                  readAcknowledge,
  output logic [DATA_WIDTH-1:0] readData,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic                  writeAcknowledge,
  input  logic                  refresh,
  output logic                  refreshAcknowledge,
  output logic                  busy,
  output logic                  rangeError
);

  localparam int DEPTH = 1 << MEM_ADDR_BITS;
  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACK,
    RD_WAIT,
    RD_ACK,
    REFRESH,
    REF_ACK
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      ref_cnt_q, ref_cnt_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  ref_ack_q, ref_ack_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  range_err_q, range_err_d;
  logic                  rd_oor_q, rd_oor_d;

  logic                  mem_we;
  logic                  mem_re;
  logic                  wr_oor;
  logic                  rd_oor;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  assign wr_oor = |writeAddress[ADDR_WIDTH-1:MEM_ADDR_BITS];
  assign rd_oor = |readAddress[ADDR_WIDTH-1:MEM_ADDR_BITS];

  // Word store: no reset so it maps onto block RAM and survives rst.
  always_ff @(posedge clkDiv) begin
    if (mem_we) begin
      mem[writeAddress[MEM_ADDR_BITS-1:0]] <= writeData;
    end
    if (mem_re) begin
      ram_q <= mem[readAddress[MEM_ADDR_BITS-1:0]];
    end
  end

  always_ff @(posedge clkDiv or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ref_cnt_q   <= '0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      ref_ack_q   <= 1'b0;
      rd_data_q   <= '0;
      range_err_q <= 1'b0;
      rd_oor_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_cnt_q   <= ref_cnt_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
      ref_ack_q   <= ref_ack_d;
      rd_data_q   <= rd_data_d;
      range_err_q <= range_err_d;
      rd_oor_q    <= rd_oor_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ref_cnt_d   = ref_cnt_q;
    rd_ack_d    = 1'b0;
    wr_ack_d    = 1'b0;
    ref_ack_d   = 1'b0;
    rd_data_d   = rd_data_q;
    range_err_d = range_err_q;
    rd_oor_d    = rd_oor_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    case (state_q)
      IDLE: begin
        // Refresh wins so it slots in between words of a running burst.
        if (refresh) begin
          ref_cnt_d = CNT_W'(REFRESH_CYCLES - 1);
          state_d   = REFRESH;
        end else if (write) begin
          mem_we   = ~wr_oor;
          wr_ack_d = 1'b1;
          if (wr_oor) range_err_d = 1'b1;
          state_d  = WR_ACK;
        end else if (read) begin
          mem_re   = 1'b1;
          rd_oor_d = rd_oor;
          if (rd_oor) range_err_d = 1'b1;
          state_d  = RD_WAIT;
        end
      end
      WR_ACK:  state_d = IDLE;
      RD_WAIT: begin
        rd_data_d = rd_oor_q ? '0 : ram_q;
        rd_ack_d  = 1'b1;
        state_d   = RD_ACK;
      end
      RD_ACK:  state_d = IDLE;
      REFRESH: begin
        if (ref_cnt_q == '0) begin
          ref_ack_d = 1'b1;
          state_d   = REF_ACK;
        end else begin
          ref_cnt_d = ref_cnt_q - 1'b1;
        end
      end
      REF_ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign readAcknowledge    = rd_ack_q;
  assign readData           = rd_data_q;
  assign writeAcknowledge   = wr_ack_q;
  assign refreshAcknowledge = ref_ack_q;
  assign busy               = (state_q != IDLE);
  assign rangeError         = range_err_q;

endmodule

// File: tb/tb_row_store_responder.sv
// Bench for row_store_responder: a requester model drives bursts and a queue
// of expected read words is checked as read acknowledges come back.
module tb_row_store_responder;

  localparam int R = 8;

  logic        clkDiv = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        refresh = 1'b0;
  logic [23:0] readAddress = '0;
  logic [23:0] writeAddress = '0;
  logic [15:0] writeData = '0;
  logic        readAcknowledge;
  logic        writeAcknowledge;
  logic        refreshAcknowledge;
  logic        busy;
  logic        rangeError;
  logic [15:0] readData;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [15:0] model [0:32767];
  logic [15:0] rd_exp_q [$];
  int wr_gaps [$];
  logic prev_r = 1'b0, prev_w = 1'b0, prev_f = 1'b0;

  row_store_responder #(.REFRESH_CYCLES(R)) dut (
    .clkDiv(clkDiv), .rst(rst),
    .read(read), .readAddress(readAddress),
    .readAcknowledge(readAcknowledge), .readData(readData),
    .write(write), .writeAddress(writeAddress), .writeData(writeData),
    .writeAcknowledge(writeAcknowledge),
    .refresh(refresh), .refreshAcknowledge(refreshAcknowledge),
    .busy(busy), .rangeError(rangeError)
  );

  always #5 clkDiv = ~clkDiv;
  always @(posedge clkDiv) cyc <= cyc + 1;

  // Acknowledges must be exclusive single-cycle pulses.
  always @(negedge clkDiv) begin
    if (!rst && (readAcknowledge || writeAcknowledge || refreshAcknowledge)) begin
      tests++;
      if ((int'(readAcknowledge) + int'(writeAcknowledge) + int'(refreshAcknowledge)) > 1 ||
          (readAcknowledge && prev_r) || (writeAcknowledge && prev_w) ||
          (refreshAcknowledge && prev_f)) begin
        fails++;
        $display("FAIL ack_pulse: acks r/w/f=%b%b%b prev=%b%b%b, required one single-cycle ack",
                 readAcknowledge, writeAcknowledge, refreshAcknowledge, prev_r, prev_w, prev_f);
      end
    end
    prev_r <= rst ? 1'b0 : readAcknowledge;
    prev_w <= rst ? 1'b0 : writeAcknowledge;
    prev_f <= rst ? 1'b0 : refreshAcknowledge;
  end

  task automatic tick();
    @(posedge clkDiv);
    #1;
  endtask

  // Single write access; lat = edges from request to visible ack, -1 on timeout.
  task automatic drive_write(input logic [23:0] addr, input logic [15:0] data, output int lat);
    lat = -1;
    write = 1'b1; writeAddress = addr; writeData = data;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (writeAcknowledge === 1'b1) begin
        lat = i;
        break;
      end
    end
    write = 1'b0;
    if (lat > 0 && addr[23:15] == 9'd0) model[addr[14:0]] = data;
    tick();
  endtask

  task automatic drive_read(input logic [23:0] addr, output int lat, output logic [15:0] data);
    lat = -1; data = 'x;
    read = 1'b1; readAddress = addr;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (readAcknowledge === 1'b1) begin
        lat = i; data = readData;
        break;
      end
    end
    read = 1'b0;
    tick();
  endtask

  // 40-word write burst; refresh is raised after word ref_after is acknowledged.
  task automatic write_burst(input logic [23:0] base, input logic [15:0] dbase, input int ref_after,
                             output int n_wr, output int span, output int ref_gap, output int wr_before_ref);
    int last, t0, a_ref;
    wr_gaps.delete();
    n_wr = 0; ref_gap = -1; wr_before_ref = -1; last = -1; a_ref = -1;
    write = 1'b1; writeAddress = base; writeData = dbase; t0 = cyc;
    for (int i = 0; i < 400 && (write || refresh); i++) begin
      tick();
      if (writeAcknowledge === 1'b1) begin
        if (last >= 0) wr_gaps.push_back(cyc - last);
        last = cyc;
        model[writeAddress[14:0]] = writeData;
        n_wr++;
        if (n_wr == 40) write = 1'b0;
        else begin writeAddress++; writeData++; end
        if (n_wr - 1 == ref_after) begin refresh = 1'b1; a_ref = cyc; end
      end
      if (refreshAcknowledge === 1'b1) begin
        refresh = 1'b0; ref_gap = cyc - a_ref; wr_before_ref = n_wr;
      end
    end
    write = 1'b0; refresh = 1'b0;
    tick();
    span = cyc - t0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if ({readAcknowledge, writeAcknowledge, refreshAcknowledge, busy, rangeError} !== 5'b0 || readData !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got acks/busy/err=%b data=%h, required all 0",
               {readAcknowledge, writeAcknowledge, refreshAcknowledge, busy, rangeError}, readData);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset: busy=%b required 0", busy); end
  endtask

  task automatic test_single_word();
    int lat; logic [15:0] d, exp;
    drive_write(24'h000143, 16'hBEEF, lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL wr_latency: got %0d required 1", lat); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_idle: busy=%b required 0", busy); end
    rd_exp_q.push_back(16'hBEEF);
    drive_read(24'h000143, lat, d);
    exp = rd_exp_q.pop_front();
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL rd_latency: got %0d required 2", lat); end
    tests++;
    if (d !== exp) begin fails++; $display("FAIL rd_single_data: got %h required %h", d, exp); end
  endtask

  task automatic test_write_burst();
    int n, span, rg, wb, bad;
    write_burst(24'h0077C0, 16'h0000, -1, n, span, rg, wb);
    bad = 0;
    foreach (wr_gaps[k]) if (wr_gaps[k] != 2) bad++;
    tests++;
    if (n !== 40) begin fails++; $display("FAIL wr_burst_count: got %0d required 40", n); end
    tests++;
    if (span !== 80) begin fails++; $display("FAIL wr_burst_span: got %0d required 80", span); end
    tests++;
    if (bad !== 0 || wr_gaps.size() !== 39) begin
      fails++; $display("FAIL wr_burst_gap: %0d gaps not 2 of %0d, required 0 of 39", bad, wr_gaps.size());
    end
  endtask

  task automatic test_read_burst(input string name, input logic [23:0] base);
    int last, n, t0; logic [15:0] exp;
    n = 0; last = -1; rd_exp_q.delete();
    read = 1'b1; readAddress = base; rd_exp_q.push_back(model[base[14:0]]); t0 = cyc;
    for (int i = 0; i < 400 && read; i++) begin
      tick();
      if (readAcknowledge === 1'b1) begin
        tests++;
        if (rd_exp_q.size() == 0) begin
          fails++; $display("FAIL %s_unexpected: got ack with data %h, required none", name, readData);
        end else begin
          exp = rd_exp_q.pop_front();
          if (readData !== exp) begin
            fails++; $display("FAIL %s_data: word %0d got %h required %h", name, n, readData, exp);
          end
        end
        if (last >= 0) begin
          tests++;
          if (cyc - last !== 3) begin
            fails++; $display("FAIL %s_gap: word %0d gap %0d required 3", name, n, cyc - last);
          end
        end
        last = cyc; n++;
        if (n == 40) read = 1'b0;
        else begin readAddress++; rd_exp_q.push_back(model[readAddress[14:0]]); end
      end
    end
    read = 1'b0;
    tick();
    tests++;
    if (n !== 40) begin fails++; $display("FAIL %s_count: got %0d required 40", name, n); end
    tests++;
    if (cyc - t0 !== 120) begin fails++; $display("FAIL %s_span: got %0d required 120", name, cyc - t0); end
    rd_exp_q.delete();
  endtask

  task automatic test_refresh_mid_burst();
    int n, span, rg, wb, bad, odd;
    write_burst(24'h001900, 16'hA000, 17, n, span, rg, wb);
    bad = 0; odd = 0;
    foreach (wr_gaps[k]) begin
      if (wr_gaps[k] == R + 4) odd++;
      else if (wr_gaps[k] != 2) bad++;
    end
    tests++;
    if (rg !== R + 2) begin fails++; $display("FAIL ref_latency: got %0d required %0d", rg, R + 2); end
    tests++;
    if (wb !== 18) begin fails++; $display("FAIL ref_priority: writes before ref ack %0d required 18", wb); end
    tests++;
    if (n !== 40 || span !== 80 + R + 2) begin
      fails++; $display("FAIL ref_burst_span: count %0d span %0d required 40 and %0d", n, span, 80 + R + 2);
    end
    tests++;
    if (bad !== 0 || odd !== 1) begin
      fails++; $display("FAIL ref_burst_gaps: bad %0d long %0d required 0 and 1", bad, odd);
    end
  endtask

  task automatic test_simultaneous();
    int nw, t_drop, got; logic [15:0] exp;
    nw = 0; t_drop = -1; got = 0; rd_exp_q.delete();
    write = 1'b1; read = 1'b1;
    writeAddress = 24'h000A00; writeData = 16'h1111; readAddress = 24'h000A01;
    for (int i = 0; i < 40 && (write || read); i++) begin
      tick();
      if (writeAcknowledge === 1'b1) begin
        model[writeAddress[14:0]] = writeData;
        nw++;
        if (nw == 1) begin writeAddress = 24'h000A01; writeData = 16'h5A5A; end
        else begin write = 1'b0; t_drop = cyc; rd_exp_q.push_back(16'h5A5A); end
      end
      if (readAcknowledge === 1'b1) begin
        got++; read = 1'b0;
        tests++;
        if (nw !== 2 || rd_exp_q.size() == 0) begin
          fails++; $display("FAIL sim_order: read acked after %0d writes, required 2", nw);
        end else begin
          exp = rd_exp_q.pop_front();
          tests++;
          if (readData !== exp) begin fails++; $display("FAIL sim_data: got %h required %h", readData, exp); end
          tests++;
          if (cyc - t_drop !== 3) begin
            fails++; $display("FAIL sim_latency: got %0d required 3", cyc - t_drop);
          end
        end
      end
    end
    write = 1'b0; read = 1'b0;
    tick();
    tests++;
    if (nw !== 2 || got !== 1) begin
      fails++; $display("FAIL sim_counts: writes %0d reads %0d required 2 and 1", nw, got);
    end
  endtask

  task automatic test_range();
    int lat; logic [15:0] d, exp;
    drive_write(24'h000000, 16'h0F0F, lat);
    tests++;
    if (rangeError !== 1'b0) begin fails++; $display("FAIL range_clear: rangeError=%b required 0", rangeError); end
    drive_write(24'h010000, 16'h1234, lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL range_wr_ack: latency %0d required 1", lat); end
    tests++;
    if (rangeError !== 1'b1) begin fails++; $display("FAIL range_wr_flag: rangeError=%b required 1", rangeError); end
    rd_exp_q.push_back(16'h0F0F);
    drive_read(24'h000000, lat, d);
    exp = rd_exp_q.pop_front();
    tests++;
    if (d !== exp) begin fails++; $display("FAIL range_mem0: got %h required %h", d, exp); end
    repeat (3) tick();
    tests++;
    if (readData !== 16'h0F0F) begin fails++; $display("FAIL rd_hold: got %h required 0f0f", readData); end
    rd_exp_q.push_back(16'h0000);
    drive_read(24'h800005, lat, d);
    exp = rd_exp_q.pop_front();
    tests++;
    if (lat !== 2 || d !== exp) begin
      fails++; $display("FAIL range_rd: latency %0d data %h required 2 and %h", lat, d, exp);
    end
    tests++;
    if (rangeError !== 1'b1) begin fails++; $display("FAIL range_sticky: rangeError=%b required 1", rangeError); end
  endtask

  task automatic test_reset_mid_read();
    int lat; logic [15:0] d, exp;
    drive_write(24'h000200, 16'h7E57, lat);
    drive_read(24'h000200, lat, d);
    tests++;
    if (d !== 16'h7E57) begin fails++; $display("FAIL pre_reset_rd: got %h required 7e57", d); end
    read = 1'b1; readAddress = 24'h000200;
    tick();
    tests++;
    if (busy !== 1'b1 || readAcknowledge !== 1'b0) begin
      fails++; $display("FAIL rd_wait_state: busy=%b ack=%b required 1 and 0", busy, readAcknowledge);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({readAcknowledge, writeAcknowledge, refreshAcknowledge, busy, rangeError} !== 5'b0 || readData !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid_read: got acks/busy/err=%b data=%h, required all 0",
               {readAcknowledge, writeAcknowledge, refreshAcknowledge, busy, rangeError}, readData);
    end
    read = 1'b0;
    repeat (2) tick();
    tests++;
    if (readAcknowledge !== 1'b0) begin fails++; $display("FAIL reset_no_ack: ack=%b required 0", readAcknowledge); end
    rst = 1'b0;
    tick();
    rd_exp_q.push_back(16'h7E57);
    drive_read(24'h000200, lat, d);
    exp = rd_exp_q.pop_front();
    tests++;
    if (lat !== 2 || d !== exp) begin
      fails++; $display("FAIL post_reset_rd: latency %0d data %h required 2 and %h", lat, d, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_write_burst();
    test_read_burst("rd_burst_row479", 24'h0077C0);
    test_refresh_mid_burst();
    test_read_burst("rd_burst_refresh", 24'h001900);
    test_simultaneous();
    test_range();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
